// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W core: pipeline-register stall/flush,
// E-stage operand forwarding, load-use bubbles, data-memory wait handling and memory-timeout fault.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       regA_addr_D,
    input  logic [3:0]       regB_addr_D,
    input  logic [3:0]       regA_addr_E,
    input  logic [3:0]       regB_addr_E,
    input  logic [3:0]       regScr_E,
    input  logic             regw_E,
    input  logic             regmem_E,
    input  logic             pcload_E,
    input  logic [3:0]       regScr_M,
    input  logic             regw_M,
    input  logic             memop_M,
    input  logic             mem_ready,
    input  logic [3:0]       regScr_W,
    input  logic             regw_W,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDSTALL,
        ST_MEMWAIT,
        ST_FAULT
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [15:0]      wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             lduse;
    logic             memwait;

    assign lduse   = regmem_E & regw_E & ((regScr_E == regA_addr_D) | (regScr_E == regB_addr_D));
    assign memwait = memop_M & ~mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        stall_F       = 1'b0;
        stall_D       = 1'b0;
        stall_E       = 1'b0;
        stall_M       = 1'b0;
        flush_D       = 1'b0;
        flush_E       = 1'b0;
        case (state_reg)
            ST_RUN, ST_LDSTALL: begin
                // A memory wait freezes everything, so a branch resolved this cycle is held, not taken.
                if (memwait) begin
                    {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
                    wait_cnt_next = '0;
                    state_next    = ST_MEMWAIT;
                end else if (pcload_E) begin
                    flush_D    = 1'b1;
                    flush_E    = 1'b1;
                    state_next = ST_RUN;
                end else if (lduse && (state_reg == ST_RUN)) begin
                    stall_F    = 1'b1;
                    stall_D    = 1'b1;
                    flush_E    = 1'b1;
                    state_next = ST_LDSTALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
                if (mem_ready) begin
                    stall_M       = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = ST_RUN;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    state_next = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            ST_FAULT: begin
                {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
            end
            default: state_next = ST_RUN;
        endcase
        // Held in reset the pipe is kept empty rather than frozen.
        if (!rst) begin
            {stall_F, stall_D, stall_E, stall_M} = 4'b0000;
            flush_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    assign mem_err = (state_reg == ST_FAULT);

    logic [1:0][3:0] src_addr;
    logic [1:0][1:0] fwd_sel;

    assign src_addr[0] = regA_addr_E;
    assign src_addr[1] = regB_addr_E;

    // The younger producer in M beats W when both target the same register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] = !rst                                    ? 2'b00 :
                             (regw_M && (regScr_M == src_addr[gi])) ? 2'b10 :
                             (regw_W && (regScr_W == src_addr[gi])) ? 2'b01 : 2'b00;
    end

    assign fwdA_E = fwd_sel[0];
    assign fwdB_E = fwd_sel[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_F && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule
